// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encoding,
// default parameter values and the hard-wired zero register index.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } hz_state_t;

    localparam int         CNT_W_DEF     = 16;
    localparam int         DRAIN_CYC_DEF = 1;
    localparam logic [3:0] REG_ZERO      = 4'h0;

endpackage

// File: rtl/dff.sv
// Plain W-bit D flip-flop with synchronous active-high reset to RST_VAL.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (i_rst) o_q <= RST_VAL;
        else       o_q <= i_d;
    end

endmodule

// File: rtl/hazard_sat_counter.sv
// CNT_W-bit event counter with synchronous reset; sticks at all-ones.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst)                         r_count <= '0;
        else if (i_inc && (r_count != '1)) r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use stalls, branch
// flushes, halt drain sequencing and saturating stall/flush perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_Operand1,
    input  logic [3:0]       D_Operand2_Fw,
    input  logic             D_uses_op1,
    input  logic             D_uses_op2,
    input  logic [3:0]       X_Destination,
    input  logic             X_MemRead,
    input  logic             X_RegWrite,
    input  logic             X_hlt,
    input  logic             X_branch_taken,
    input  logic             mem_busy,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_wen,
    output logic             idex_flush,
    output logic             exmem_wen,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int           DW         = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC);

    logic [1:0]       w_state_q;
    hz_state_t        w_state;
    hz_state_t        w_state_nxt;
    logic [DW-1:0]    w_drain_q;
    logic [DW-1:0]    w_drain_nxt;
    logic             w_lu;
    logic             w_inc_stall;
    logic             w_inc_flush;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    dff #(.W(2), .RST_VAL(2'b00)) u_state_ff (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (w_state_nxt),
        .o_q   (w_state_q)
    );

    dff #(.W(DW), .RST_VAL('0)) u_drain_ff (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (w_drain_nxt),
        .o_q   (w_drain_q)
    );

    assign w_state = hz_state_t'(w_state_q);

    assign w_lu = X_MemRead && X_RegWrite && (X_Destination != REG_ZERO) &&
                  ((D_uses_op1 && (D_Operand1    == X_Destination)) ||
                   (D_uses_op2 && (D_Operand2_Fw == X_Destination)));

    // Every flush is paired with its write enable so the NOP actually lands.
    always_comb begin
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        ifid_flush  = 1'b0;
        idex_wen    = 1'b0;
        idex_flush  = 1'b0;
        exmem_wen   = 1'b0;
        w_inc_stall = 1'b0;
        w_inc_flush = 1'b0;
        w_state_nxt = w_state;
        w_drain_nxt = w_drain_q;
        if (!rst) begin
            case (w_state)
                ST_RUN: begin
                    if (mem_busy) begin
                        // everything holds
                    end else if (X_hlt) begin
                        idex_wen    = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_wen   = 1'b1;
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = DRAIN_INIT;
                    end else if (X_branch_taken) begin
                        pc_wen      = 1'b1;
                        ifid_wen    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_wen    = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_wen   = 1'b1;
                        w_inc_flush = 1'b1;
                    end else if (w_lu) begin
                        idex_wen    = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_wen   = 1'b1;
                        w_inc_stall = 1'b1;
                    end else begin
                        pc_wen      = 1'b1;
                        ifid_wen    = 1'b1;
                        idex_wen    = 1'b1;
                        exmem_wen   = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!mem_busy) begin
                        idex_wen   = 1'b1;
                        idex_flush = 1'b1;
                        exmem_wen  = 1'b1;
                        if (w_drain_q == '0) w_state_nxt = ST_HALTED;
                        else                 w_drain_nxt = w_drain_q - 1'b1;
                    end
                end
                ST_HALTED: begin
                    w_state_nxt = ST_HALTED;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_inc_stall),
        .o_count (w_stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_inc_flush),
        .o_count (w_flush_cnt)
    );

    // Registered status is masked while rst is held so it reads cleared at once.
    assign halted      = (w_state == ST_HALTED) && !rst;
    assign stall_count = rst ? '0 : w_stall_cnt;
    assign flush_count = rst ? '0 : w_flush_cnt;

endmodule
